daq_stream_arbiter: RTL and testbench

DAQ_STREAM_ARBITER -- requirements
Module: daq_stream_arbiter

---
 rtl/daq_arb_pkg.sv | 26 ++
 rtl/rr_next_sel.sv | 40 ++++
 rtl/daq_stream_arbiter.sv | 174 +++++++++++++++++
 tb/tb_daq_stream_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_arb_pkg.sv
// Shared definitions for the DAQ stream arbiter: FSM state encoding,
// source-tag field position, burst counter and grant index widths.
package daq_arb_pkg;

  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 29;
  localparam int BURST_W = 8;
  localparam int GRANT_W = 3;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    ROTATE = 2'd2
  } arb_state_e;

  // Replace the top bits of a word with the index of the source it came from.
  function automatic logic [WORD_W-1:0] tag_word(input logic [WORD_W-1:0]  word,
                                                 input logic [GRANT_W-1:0] src);
    logic [WORD_W-1:0] r;
    r = word;
    r[TAG_MSB:TAG_LSB] = src;
    return r;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin next-grant selector. Searches the non-empty vector starting
// one past the last grant and wrapping, so the last granted source is
// considered only after every other source (a lone source still wins).
module rr_next_sel
  import daq_arb_pkg::*;
#(
  parameter int N_SRC = 2
) (
  input  logic [N_SRC-1:0]   nonempty,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] next,
  output logic               any
);

  localparam int CW = GRANT_W + 1;

  logic [CW-1:0] cand [N_SRC];

  // Candidate order: last+1, last+2, ... modulo N_SRC, first hit wins.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next = '0;
    any  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      cand[k] = {1'b0, last} + CW'(k + 1);
      if (cand[k] >= CW'(N_SRC)) begin
        cand[k] = cand[k] - CW'(N_SRC);
      end
    end
    for (int k = 0; k < N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!any && (cand[k] == CW'(i)) && nonempty[i]) begin
          any  = 1'b1;
          next = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/daq_stream_arbiter.sv
// DAQ stream arbiter: merges N_SRC first-word-fall-through word sources
// into one registered output stream for a downstream bram_fifo reader.
// Grants rotate round-robin, at most MAX_BURST words per grant, with a
// one-cycle ROTATE turnaround between grants.
// Optional build macro ARB_SRC_TAG_EN: stamps the source index into
// ARB_DATA_OUT[31:29]; undefined, words pass through unmodified.
module daq_stream_arbiter
  import daq_arb_pkg::*;
#(
  parameter int N_SRC     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                  BUS_CLK,
  input  logic                  RESETB,
  input  logic [N_SRC-1:0]      SRC_EMPTY,
  input  logic [32*N_SRC-1:0]   SRC_DATA,
  output logic [N_SRC-1:0]      SRC_READ,
  input  logic                  ARB_READY_OUT,
  output logic                  ARB_WRITE_OUT,
  output logic [31:0]           ARB_DATA_OUT,
  output logic [2:0]            GRANT_OUT,
  output logic [31:0]           WORD_CNT
);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [GRANT_W-1:0] GRANT_RST  = GRANT_W'(N_SRC - 1);

  arb_state_e         state;
  logic [GRANT_W-1:0] grant;
  logic [GRANT_W-1:0] last_grant;
  logic [BURST_W-1:0] burst_cnt;

  logic               out_valid;
  logic [31:0]        out_data;
  logic [31:0]        word_cnt;

  logic [N_SRC-1:0]   nonempty;
  logic               any_ne;
  logic [GRANT_W-1:0] sel_idx;
  logic               sel_any;

  logic               grant_empty;
  logic [31:0]        grant_word;
  logic [31:0]        pop_word;
  logic               out_free;
  logic               consume;
  logic               pop;
  logic               burst_hit;

  assign nonempty = ~SRC_EMPTY;
  assign any_ne   = |nonempty;

  // Head word and empty flag of the currently granted source.
  always_comb begin
    grant_empty = 1'b1;
    grant_word  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant == GRANT_W'(i)) begin
        grant_empty = SRC_EMPTY[i];
        grant_word  = SRC_DATA[32*i +: 32];
      end
    end
  end

  // Word as it will be registered; optionally stamped with its source.
  always_comb begin
`ifdef ARB_SRC_TAG_EN
    pop_word = tag_word(grant_word, grant);
`else
    pop_word = grant_word;
`endif
  end

  // A word leaves on valid & ready; ready alone is ignored. The register
  // can accept a new word if it is empty or being drained this cycle.
  assign consume   = out_valid & ARB_READY_OUT;
  assign out_free  = ~out_valid | ARB_READY_OUT;

  // Pop decision uses the live empty flag, so a source that goes empty in
  // this cycle is never strobed. State resets asynchronously to IDLE, so
  // no strobe survives a reset assertion.
  assign pop       = (state == SERVE) & ~grant_empty & out_free;
  assign burst_hit = pop & (burst_cnt == BURST_LAST);

  // One-hot pop strobe towards the granted source only.
  always_comb begin
    SRC_READ = '0;
    for (int i = 0; i < N_SRC; i++) begin
      SRC_READ[i] = pop & (grant == GRANT_W'(i));
    end
  end

  rr_next_sel #(
    .N_SRC (N_SRC)
  ) u_rr_next_sel (
    .nonempty (nonempty),
    .last     (last_grant),
    .next     (sel_idx),
    .any      (sel_any)
  );

  // Grant FSM: IDLE picks a source, SERVE streams up to MAX_BURST words,
  // ROTATE is a no-pop turnaround before the next round-robin pick.
  always_ff @(posedge BUS_CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GRANT_RST;
      burst_cnt  <= '0;
    end else begin
      // NOTE: state registers use <= so each one samples pre-edge values.
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant      <= sel_idx;
            last_grant <= sel_idx;
            burst_cnt  <= '0;
            state      <= SERVE;
          end
        end
        SERVE: begin
          if (pop) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_hit) begin
              state <= ROTATE;
            end
          end else if (grant_empty) begin
            // Granted source dried up: hand over if anyone else has data.
            state <= any_ne ? ROTATE : IDLE;
          end
        end
        ROTATE: begin
          if (sel_any) begin
            grant      <= sel_idx;
            last_grant <= sel_idx;
            burst_cnt  <= '0;
            state      <= SERVE;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output register and delivered-word counter; a word held at reset is
  // dropped rather than delivered.
  always_ff @(posedge BUS_CLK or negedge RESETB) begin
    if (!RESETB) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= pop_word;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (consume) begin
        word_cnt <= word_cnt + 32'd1;
      end
    end
  end

  assign ARB_WRITE_OUT = out_valid;
  assign ARB_DATA_OUT  = out_data;
  assign GRANT_OUT     = grant;
  assign WORD_CNT      = word_cnt;

endmodule

// File: tb/tb_daq_stream_arbiter.sv
// Self-checking bench for daq_stream_arbiter (N_SRC=2, MAX_BURST=16).
// Sources are modelled as FWFT queues; a reference model derives the
// delivered word order from the round-robin / burst rules, and one
// monitor compares the DUT against it every cycle.
module tb_daq_stream_arbiter;

  localparam int NS = 2;
  localparam int MB = 16;

  logic          BUS_CLK = 1'b0;
  logic          RESETB;
  logic [NS-1:0] SRC_EMPTY;
  logic [63:0]   SRC_DATA;
  logic [NS-1:0] SRC_READ;
  logic          ARB_READY_OUT;
  logic          ARB_WRITE_OUT;
  logic [31:0]   ARB_DATA_OUT;
  logic [2:0]    GRANT_OUT;
  logic [31:0]   WORD_CNT;

  daq_stream_arbiter #(.N_SRC(NS), .MAX_BURST(MB)) dut (
    .BUS_CLK       (BUS_CLK),
    .RESETB        (RESETB),
    .SRC_EMPTY     (SRC_EMPTY),
    .SRC_DATA      (SRC_DATA),
    .SRC_READ      (SRC_READ),
    .ARB_READY_OUT (ARB_READY_OUT),
    .ARB_WRITE_OUT (ARB_WRITE_OUT),
    .ARB_DATA_OUT  (ARB_DATA_OUT),
    .GRANT_OUT     (GRANT_OUT),
    .WORD_CNT      (WORD_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  logic [31:0] fq0[$];
  logic [31:0] fq1[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] model_cnt = '0;
  int          model_last = NS - 1;
  int          cyc = 0;
  int          first_cons = -1;
  int          last_cons = -1;
  int          pops_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tag_word(input logic [31:0] w, input int s);
    logic [31:0] r;
    r = w;
`ifdef ARB_SRC_TAG_EN
    r[31:29] = 3'(s);
`endif
    return r;
  endfunction

  task automatic drive_srcs();
    SRC_EMPTY[0]    = (fq0.size() == 0);
    SRC_EMPTY[1]    = (fq1.size() == 0);
    SRC_DATA[31:0]  = (fq0.size() != 0) ? fq0[0] : 32'h0;
    SRC_DATA[63:32] = (fq1.size() != 0) ? fq1[0] : 32'h0;
  endtask

  task automatic load(input int s, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      if (s == 0) fq0.push_back(base + 32'(i));
      else        fq1.push_back(base + 32'(i));
    end
  endtask

  // Reference order: pick the first non-empty source after the last one
  // granted, take up to MB words from it, repeat until everything is gone.
  task automatic build_expected();
    int h0, h1, g, n;
    h0 = 0;
    h1 = 0;
    while (h0 < fq0.size() || h1 < fq1.size()) begin
      g = -1;
      for (int k = 1; k <= NS; k++) begin
        int c;
        c = (model_last + k) % NS;
        if (g < 0 && ((c == 0 && h0 < fq0.size()) || (c == 1 && h1 < fq1.size()))) g = c;
      end
      n = 0;
      while (n < MB && ((g == 0 && h0 < fq0.size()) || (g == 1 && h1 < fq1.size()))) begin
        if (g == 0) begin exp_q.push_back(tag_word(fq0[h0], 0)); h0++; end
        else        begin exp_q.push_back(tag_word(fq1[h1], 1)); h1++; end
        n++;
      end
      model_last = g;
    end
  endtask

  task automatic start_test();
    got_q.delete();
    first_cons = -1;
    last_cons  = -1;
    pops_seen  = 0;
  endtask

  task automatic wait_drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge BUS_CLK);
      if (exp_q.size() == 0 && !ARB_WRITE_OUT && fq0.size() == 0 && fq1.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_got(input int n, input int max_cyc);
    int t;
    t = 0;
    while (got_q.size() < n && t < max_cyc) begin
      @(negedge BUS_CLK);
      t++;
    end
    if (got_q.size() < n) check("got_timeout", 32'(got_q.size()), 32'(n));
  endtask

  // Per-cycle monitor: samples just before each rising edge, then applies
  // the pops the DUT strobed to the source queues just after the edge.
  logic [NS-1:0] pend;
  logic          prev_stall = 1'b0;
  logic [31:0]   prev_data  = '0;

  always begin
    @(negedge BUS_CLK);
    #4;
    cyc++;
    pend = SRC_READ;
    if (RESETB) begin
      check("word_cnt", WORD_CNT, model_cnt);
      if (SRC_READ != '0) begin
        check("read_onehot", 32'($countones(SRC_READ)), 32'd1);
        for (int i = 0; i < NS; i++)
          if (SRC_READ[i]) check("read_nonempty", 32'(SRC_EMPTY[i]), 32'd0);
      end
      if (ARB_WRITE_OUT && !ARB_READY_OUT) check("stall_no_read", 32'(SRC_READ), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(ARB_WRITE_OUT), 32'd1);
        check("stall_data", ARB_DATA_OUT, prev_data);
      end
      if (ARB_WRITE_OUT && ARB_READY_OUT) begin
        if (exp_q.size() == 0) check("extra_word", ARB_DATA_OUT, 32'hDEAD_BEEF);
        else check("word_order", ARB_DATA_OUT, exp_q.pop_front());
        got_q.push_back(ARB_DATA_OUT);
        model_cnt = model_cnt + 32'd1;
        if (first_cons < 0) first_cons = cyc;
        last_cons = cyc;
      end
      pops_seen += $countones(SRC_READ);
      prev_stall = ARB_WRITE_OUT && !ARB_READY_OUT;
      prev_data  = ARB_DATA_OUT;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge BUS_CLK);
    #1;
    if (pend[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (pend[1] && fq1.size() != 0) void'(fq1.pop_front());
    drive_srcs();
  end

  int n_rem;

  initial begin
    RESETB        = 1'b0;
    ARB_READY_OUT = 1'b0;
    drive_srcs();
    repeat (3) @(negedge BUS_CLK);
    check("rst_write", 32'(ARB_WRITE_OUT), 32'd0);
    check("rst_data", ARB_DATA_OUT, 32'd0);
    check("rst_read", 32'(SRC_READ), 32'd0);
    check("rst_grant", 32'(GRANT_OUT), 32'd0);
    check("rst_cnt", WORD_CNT, 32'd0);
    RESETB = 1'b1;

    // Two sources of 20 words each: 16/16/4/4 interleave.
    @(negedge BUS_CLK);
    start_test();
    ARB_READY_OUT = 1'b1;
    load(0, 20, 32'h0000_0100);
    load(1, 20, 32'h2000_0200);
    build_expected();
    drive_srcs();
    wait_drain(400);
    check("b_count", 32'(got_q.size()), 32'd40);
    check("b_w0", got_q[0], 32'h0000_0100);
    check("b_w15", got_q[15], 32'h0000_010F);
    check("b_w16", got_q[16], 32'h2000_0200);
    check("b_w32", got_q[32], 32'h0000_0110);
    check("b_w36", got_q[36], 32'h2000_0210);
    check("b_w39", got_q[39], 32'h2000_0213);
    check("b_cnt", WORD_CNT, 32'd40);

    // Lone source, 40 words: bursts of 16 separated by one idle cycle.
    @(negedge BUS_CLK);
    start_test();
    load(0, 40, 32'h0000_0100);
    build_expected();
    drive_srcs();
    wait_drain(400);
    check("a_count", 32'(got_q.size()), 32'd40);
    check("a_w16", got_q[16], 32'h0000_0110);
    check("a_span", 32'(last_cons - first_cons + 1), 32'd42);
    check("a_pops", 32'(pops_seen), 32'd40);
    check("a_cnt", WORD_CNT, 32'd80);

    // Back-pressure: 10 stalled cycles with word 3 held in the register.
    @(negedge BUS_CLK);
    start_test();
    load(0, 12, 32'h0000_0100);
    build_expected();
    drive_srcs();
    wait_got(3, 50);
    ARB_READY_OUT = 1'b0;
    n_rem = pops_seen;
    repeat (10) @(negedge BUS_CLK);
    check("c_hold_data", ARB_DATA_OUT, 32'h0000_0103);
    check("c_hold_valid", 32'(ARB_WRITE_OUT), 32'd1);
    check("c_stall_pops", 32'(pops_seen - n_rem), 32'd0);
    check("c_stall_got", 32'(got_q.size()), 32'd3);
    ARB_READY_OUT = 1'b1;
    wait_drain(200);
    check("c_count", 32'(got_q.size()), 32'd12);
    check("c_cnt", WORD_CNT, 32'd92);

    // Reset during a source-1 burst: held word dropped, restart at source 0.
    @(negedge BUS_CLK);
    start_test();
    load(0, 20, 32'h0000_0100);
    load(1, 20, 32'h2000_0200);
    build_expected();
    drive_srcs();
    wait_got(4, 50);
    check("d_grant_pre", 32'(GRANT_OUT), 32'd1);
    RESETB = 1'b0;
    #1;
    check("d_rst_write", 32'(ARB_WRITE_OUT), 32'd0);
    check("d_rst_data", ARB_DATA_OUT, 32'd0);
    check("d_rst_read", 32'(SRC_READ), 32'd0);
    check("d_rst_grant", 32'(GRANT_OUT), 32'd0);
    check("d_rst_cnt", WORD_CNT, 32'd0);
    repeat (3) @(negedge BUS_CLK);
    exp_q.delete();
    model_cnt  = '0;
    model_last = NS - 1;
    start_test();
    n_rem = fq0.size() + fq1.size();
    build_expected();
    RESETB = 1'b1;
    wait_drain(400);
    check("d_first", got_q[0], 32'h0000_0100);
    check("d_count", 32'(got_q.size()), 32'(n_rem));
    check("d_cnt", WORD_CNT, 32'(n_rem));

    // All-ones word from source 1: tag field shows up only with the macro.
    @(negedge BUS_CLK);
    start_test();
    load(1, 1, 32'hFFFF_FFFF);
    build_expected();
    drive_srcs();
    wait_drain(50);
`ifdef ARB_SRC_TAG_EN
    check("e_tag", got_q[0], 32'h3FFF_FFFF);
`else
    check("e_tag", got_q[0], 32'hFFFF_FFFF);
`endif
    check("e_grant", 32'(GRANT_OUT), 32'd1);

    // Counter wrap from 0xFFFFFFFE over three deliveries.
    @(negedge BUS_CLK);
    start_test();
    force dut.word_cnt = 32'hFFFF_FFFE;
    model_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.word_cnt;
    load(0, 3, 32'h0000_0100);
    build_expected();
    drive_srcs();
    wait_drain(50);
    check("f_wrap", WORD_CNT, 32'd1);

    repeat (2) @(negedge BUS_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
